soc_system_spi_slave: RTL and testbench
=======================================

# soc_system_spi_slave

SPI slave peripheral: the far end of the SPI master link, for use where the HPS/FPGA fabric must answer an external or looped-back SPI master. It implements SPI mode 0 (CPOL=0, CPHA=0), 8-bit, MSB-first framing, with a memory-mapped register port in the same style as the SPI master. All SPI inputs are oversampled by the system clock through synchronizers; no logic is clocked by SCLK.

## Interface
- DATABITS, 8, frame width in bits; fixed.
- SYNC_STAGES, 2, synchronizer depth for SCLK, SS_n and MOSI; minimum 2.
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- data_from_cpu  in  16  register write data.
- mem_addr  in  3  register address.
- read_n  in  1  read request, active-low, qualified by spi_select.
- write_n  in  1  write request, active-low, qualified by spi_select.
- spi_select  in  1  chip select for the register port.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- dataavailable  out  1  equals RRDY.
- readyfordata  out  1  equals TRDY.
- SCLK  in  1  SPI clock from the master.
- MOSI  in  1  serial data from the master.
- SS_n  in  1  slave select, active-low.
- MISO  out  1  serial data to the master; always equals shift_reg[7].
- MISO_oe  out  1  output enable for the MISO pad; equals ~ss_sync.

## Operation
- Register map: 0 rxdata (r, bits [7:0]); 1 txdata (w); 2 status (r; any write clears ROE, TOE, TUR); 3 control (r/w); all other addresses read 0.
- Status bits: [2] TUR (tx underrun), [3] ROE, [4] TOE, [5] TMT, [6] TRDY, [7] RRDY, [8] E = ROE|TOE|TUR.
- Control bits: [3] iROE, [4] iTOE, [6] iTRDY, [7] iRRDY, [8] iE. All other bits read 0.
- irq is registered and equals the OR of each status flag ANDed with its enable; E is ANDed with iE.
- Bus access: each read and each write is a two-cycle event. A strobe is raised on the first cycle, and a new strobe cannot start in the next cycle. data_to_cpu is registered from mem_addr on every clock.
- Synchronizers: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
- Edge detection: one more flop on the synchronized SCLK and SS_n generates rise and fall pulses.
- Receive: on each synced SCLK rise with SS low, shift_in <= {shift_in[6:0], mosi_sync} and bitcnt increments.
- Receive completion: on the 8th rise, rx_holding <= completed byte and RRDY <= 1. If RRDY was already 1, ROE <= 1 and rx_holding is still overwritten.
- RRDY clears on a read of address 0 or on a status write.
- Transmit: tx_holding and primed. A write to address 1 when TRDY=1 loads tx_holding[7:0] and sets primed. A write when TRDY=0 sets TOE and leaves tx_holding unchanged.
- TRDY = ~primed.
- Load event: shift_reg <= primed ? tx_holding : 8'h00, primed <= 0, fresh <= 1.
- Underrun: if the load event occurs with primed=0, TUR <= 1.
- When a load event fires: on SS fall if fresh=0, and on the SCLK fall that follows the 8th rise while SS stays low.
- Other SCLK falls (bits 2..8) with SS low: shift_reg <= {shift_reg[6:0], 1'b0}.
- fresh clears on the first SCLK rise of a byte.
- SS rise: bitcnt <= 0. A partial receive byte is discarded, with no RRDY and no ROE. A fresh preloaded byte is kept for the next SS fall. A partially sent byte is lost and is not reloaded.
- TMT = ~primed & ~fresh & (bitcnt==0).
- A write to address 1 in the same cycle as a load event: the load takes the old holding value (primed=1 path), then the write succeeds. The net result is primed=1 holding the new data.

## Timing
- Reset values: data_to_cpu=0, irq=0, MISO=0, MISO_oe=0, dataavailable=0, readyfordata=1. All flags are 0, bitcnt=0, fresh=0.
- Sample latency: MOSI is sampled SYNC_STAGES+1 clk after the SCLK rise at the pin.
- MISO latency: MISO changes SYNC_STAGES+1 clk after the SCLK fall or SS fall at the pin.
- Supported SCLK: high and low phases must each be ≥ SYNC_STAGES+2 clk, i.e. ≥ 4 clk (≤ 6.25 MHz at 50 MHz).
- SS setup: SS fall to first SCLK rise must be ≥ SYNC_STAGES+2 clk.
- Flag timing: RRDY sets in the same cycle that rx_holding updates. irq follows the flag by 1 clk.
- Register reads: the read value is valid on the second cycle of the access.
- Reset mid-frame: all state clears immediately. The next frame starts only at a new SS fall.

## Test plan
- Write 0xA5 to txdata, then the master clocks a byte sending 0x3C at 1 MHz with SS low -> master receives 0xA5; rxdata=0x3C; RRDY=1; TRDY=1, TMT=1 after the frame.
- Two frames with SS held low, tx 0x12 then 0x34 written before each load; master sends 0x55, 0xAA -> MISO shows 0x12 then 0x34; the second frame without a read sets ROE=1 and rxdata=0xAA.
- No tx write before the frame -> MISO shifts 0x00 and TUR=1; E=1; irq=1 when iE=1; a status write clears all three.
- Write txdata twice before SS fall -> second write sets TOE=1 and tx_holding keeps the first value.
- SS deasserted after 4 bits -> RRDY stays 0; next full frame with tx 0x81 reloaded receives and sends correctly.
- Assert reset_n low mid-byte -> all outputs at reset values within 1 clk; a clean frame after release passes.

Source files
------------

// File: rtl/soc_system_spi_slave.sv
// ---------------------------------------------------------------------------
// soc_system_spi_slave
//
// SPI mode 0 slave (CPOL=0, CPHA=0), 8-bit MSB-first frames, with a small
// memory-mapped register port. SCLK, SS_n and MOSI are oversampled by clk
// through synchronizers; nothing in this block is clocked by SCLK.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   data_from_cpu      register write data
//   mem_addr           register address (0 rxdata, 1 txdata, 2 status, 3 control)
//   read_n, write_n    active-low access requests, qualified by spi_select
//   spi_select         register port chip select
//   data_to_cpu        registered read data (valid on the 2nd access cycle)
//   irq                registered interrupt
//   dataavailable      RRDY
//   readyfordata       TRDY
//   SCLK, MOSI, SS_n   SPI inputs from the master
//   MISO, MISO_oe      SPI output and its pad enable
//
// Register port handshake: a read or write is recognised on the first cycle
// in which spi_select is high and read_n/write_n is low; the following cycle
// is the second half of that access and can never start a new one.
// ---------------------------------------------------------------------------
module soc_system_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_from_cpu,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe
);

    localparam logic [2:0]  LAST_BIT  = 3'(DATABITS - 1);
    localparam logic [15:0] CTRL_MASK = 16'h01D8;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d;
    logic                   ss_d;

    // SS chain resets to 1 so the bus looks deselected (MISO_oe low) and
    // a reset release never manufactures an SS fall by itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync   <= '0;
            ss_sync_r   <= '1;
            mosi_sync_r <= '0;
            sclk_d      <= 1'b0;
            ss_d        <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            sclk_d      <= sclk_sync[SYNC_STAGES-1];
            ss_d        <= ss_sync_r[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    // ------------------------------------------------------------------
    // Register port strobes (one strobe per two-cycle access)
    // ------------------------------------------------------------------
    logic rd_busy, wr_busy;
    logic rd_strobe, wr_strobe;
    logic wr_tx, wr_status, wr_ctrl, rd_rx;

    assign rd_strobe = spi_select & ~read_n  & ~rd_busy;
    assign wr_strobe = spi_select & ~write_n & ~wr_busy;
    assign wr_tx     = wr_strobe & (mem_addr == 3'd1);
    assign wr_status = wr_strobe & (mem_addr == 3'd2);
    assign wr_ctrl   = wr_strobe & (mem_addr == 3'd3);
    assign rd_rx     = rd_strobe & (mem_addr == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_busy <= 1'b0;
            wr_busy <= 1'b0;
        end else begin
            rd_busy <= rd_strobe;
            wr_busy <= wr_strobe;
        end
    end

    // ------------------------------------------------------------------
    // SPI bit-level events
    // ------------------------------------------------------------------
    logic [2:0]          bitcnt;
    logic                load_pend;   // 8th rise seen, next fall loads
    logic                fresh;       // shift_reg holds an unsent byte
    logic                primed;      // tx_holding holds an unloaded byte
    logic [DATABITS-2:0] shift_in;
    logic [DATABITS-1:0] shift_reg;
    logic [DATABITS-1:0] tx_holding;
    logic [DATABITS-1:0] rx_holding;
    logic                rrdy, roe, toe, tur;
    logic [15:0]         ctrl;

    logic rx_shift, rx_done, load_ev, tx_shift;

    assign rx_shift = sclk_rise & ~ss_s;
    assign rx_done  = rx_shift & (bitcnt == LAST_BIT);
    // A byte is loaded at the start of a transaction (unless one is still
    // waiting from an earlier load) and on the fall closing each byte.
    assign load_ev  = (ss_fall & ~fresh) | (sclk_fall & ~ss_s & load_pend);
    // Falls after rises 1..7 move the next bit onto MISO.
    assign tx_shift = sclk_fall & ~ss_s & ~load_pend & (bitcnt != 3'd0);

    // ------------------------------------------------------------------
    // Receive path and receive flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt     <= 3'd0;
            load_pend  <= 1'b0;
            shift_in   <= '0;
            rx_holding <= '0;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
        end else begin
            if (wr_status) begin
                rrdy <= 1'b0;
                roe  <= 1'b0;
            end
            if (rd_rx) begin
                rrdy <= 1'b0;
            end

            if (ss_rise) begin
                // Partial byte is dropped without touching RRDY/ROE.
                bitcnt    <= 3'd0;
                load_pend <= 1'b0;
            end else if (rx_shift) begin
                shift_in <= {shift_in[DATABITS-3:0], mosi_s};
                if (rx_done) begin
                    bitcnt     <= 3'd0;
                    load_pend  <= 1'b1;
                    rx_holding <= {shift_in, mosi_s};
                    rrdy       <= 1'b1;
                    if (rrdy) begin
                        roe <= 1'b1;
                    end
                end else begin
                    bitcnt <= bitcnt + 3'd1;
                end
            end else if (load_ev) begin
                load_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path and transmit flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            tx_holding <= '0;
            primed     <= 1'b0;
            fresh      <= 1'b0;
            toe        <= 1'b0;
            tur        <= 1'b0;
        end else begin
            if (wr_status) begin
                toe <= 1'b0;
                tur <= 1'b0;
            end

            if (rx_shift && bitcnt == 3'd0) begin
                fresh <= 1'b0;
            end

            if (load_ev) begin
                shift_reg <= primed ? tx_holding : '0;
                fresh     <= 1'b1;
                if (!primed) begin
                    tur <= 1'b1;
                end
            end else if (tx_shift) begin
                shift_reg <= {shift_reg[DATABITS-2:0], 1'b0};
            end

            // A write coinciding with a load always lands: the load has
            // already taken the old holding value this cycle.
            if (wr_tx) begin
                if (!primed || load_ev) begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    primed     <= 1'b1;
                end else begin
                    toe <= 1'b1;
                end
            end else if (load_ev) begin
                primed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control register, status word, read mux, irq
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= data_from_cpu & CTRL_MASK;
        end
    end

    logic        trdy, tmt, e_flag;
    logic [15:0] status;
    logic [15:0] rd_mux;

    assign trdy   = ~primed;
    assign tmt    = ~primed & ~fresh & (bitcnt == 3'd0);
    assign e_flag = roe | toe | tur;
    assign status = {7'd0, e_flag, rrdy, trdy, tmt, toe, roe, tur, 2'b00};

    always_comb begin
        rd_mux = 16'h0000;
        case (mem_addr)
            3'd0:    rd_mux = {{(16-DATABITS){1'b0}}, rx_holding};
            3'd2:    rd_mux = status;
            3'd3:    rd_mux = ctrl;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            data_to_cpu <= rd_mux;
            irq         <= (roe    & ctrl[3]) |
                           (toe    & ctrl[4]) |
                           (trdy   & ctrl[6]) |
                           (rrdy   & ctrl[7]) |
                           (e_flag & ctrl[8]);
        end
    end

    assign dataavailable = rrdy;
    assign readyfordata  = trdy;
    assign MISO          = shift_reg[DATABITS-1];
    assign MISO_oe       = ~ss_s;

    // Write data above the control field is never stored.
    logic unused_wdata;
    assign unused_wdata = ^data_from_cpu[15:9];

endmodule

// File: tb/tb_soc_system_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_soc_system_spi_slave
//
// Directed bench for soc_system_spi_slave: a behavioural SPI mode 0 master
// at 1 MHz (25 clk per SCLK phase) plus register-port driver tasks. Each
// scenario task checks its own results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_soc_system_spi_slave;

    localparam int HALF = 25;

    logic        clk;
    logic        reset_n;
    logic [15:0] data_from_cpu;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic        spi_select;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;
    logic        SCLK;
    logic        MOSI;
    logic        SS_n;
    logic        MISO;
    logic        MISO_oe;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    soc_system_spi_slave #(
        .DATABITS    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_from_cpu (data_from_cpu),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .spi_select    (spi_select),
        .data_to_cpu   (data_to_cpu),
        .irq           (irq),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata),
        .SCLK          (SCLK),
        .MOSI          (MOSI),
        .SS_n          (SS_n),
        .MISO          (MISO),
        .MISO_oe       (MISO_oe)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_addr      = a;
        data_from_cpu = d;
        spi_select    = 1'b1;
        write_n       = 1'b0;
        repeat (2) @(negedge clk);
        write_n       = 1'b1;
        spi_select    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        mem_addr   = a;
        spi_select = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        d = data_to_cpu;
        @(negedge clk);
        read_n     = 1'b1;
        spi_select = 1'b0;
    endtask

    task automatic spi_ss_fall();
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // n full rise/fall bit periods, MSB first; MISO sampled at each rise.
    task automatic spi_clock_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = MISO;
            SCLK  = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK  = 1'b0;
        end
    endtask

    // One byte. The last byte of a transaction raises SS while SCLK is
    // still high, then returns SCLK to idle.
    task automatic spi_byte(input logic [7:0] tx, input bit last, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = MISO;
            SCLK  = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i != 0 || !last) SCLK = 1'b0;
        end
        if (last) begin
            SS_n = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (data_to_cpu !== 16'h0000 || irq !== 1'b0 || MISO !== 1'b0 || MISO_oe !== 1'b0 ||
            dataavailable !== 1'b0 || readyfordata !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_outputs: d=%h irq=%b miso=%b oe=%b da=%b rfd=%b, need 0000 0 0 0 0 1",
                     data_to_cpu, irq, MISO, MISO_oe, dataavailable, readyfordata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h0060) begin
            tests_failed++;
            $display("FAIL reset_status: got %h need 0060", rd);
        end
        bus_read(3'd3, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_control: got %h need 0000", rd);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0]  rx;
        logic [15:0] rd;
        bus_write(3'd1, 16'h00A5);
        tests_run++;
        if (readyfordata !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_trdy_after_write: got %b need 0", readyfordata);
        end
        spi_ss_fall();
        tests_run++;
        if (MISO_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_miso_oe: got %b need 1", MISO_oe);
        end
        spi_byte(8'h3C, 1'b1, rx);
        tests_run++;
        if (rx !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_master_rx: got %h need a5", rx);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h00E0) begin
            tests_failed++;
            $display("FAIL basic_status: got %h need 00e0", rd);
        end
        bus_read(3'd0, rd);
        tests_run++;
        if (rd !== 16'h003C) begin
            tests_failed++;
            $display("FAIL basic_rxdata: got %h need 003c", rd);
        end
        tests_run++;
        if (dataavailable !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_rrdy_clear: got %b need 0", dataavailable);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  rx;
        logic [7:0]  exp;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h0012);
        exp_q.push_back(8'h12);
        spi_ss_fall();
        bus_write(3'd1, 16'h0034);
        exp_q.push_back(8'h34);
        tests_run++;
        if (readyfordata !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_trdy: got %b need 0", readyfordata);
        end
        spi_byte(8'h55, 1'b0, rx);
        exp = exp_q.pop_front();
        tests_run++;
        if (rx !== exp) begin
            tests_failed++;
            $display("FAIL b2b_master_rx0: got %h need %h", rx, exp);
        end
        spi_byte(8'hAA, 1'b1, rx);
        exp = exp_q.pop_front();
        tests_run++;
        if (rx !== exp) begin
            tests_failed++;
            $display("FAIL b2b_master_rx1: got %h need %h", rx, exp);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h01E8) begin
            tests_failed++;
            $display("FAIL b2b_status_roe: got %h need 01e8", rd);
        end
        bus_read(3'd0, rd);
        tests_run++;
        if (rd !== 16'h00AA) begin
            tests_failed++;
            $display("FAIL b2b_rxdata: got %h need 00aa", rd);
        end
    endtask

    task automatic test_underrun();
        logic [7:0]  rx;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd3, 16'h0100);
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL underrun_irq_idle: got %b need 0", irq);
        end
        spi_ss_fall();
        spi_byte(8'h0F, 1'b1, rx);
        tests_run++;
        if (rx !== 8'h00) begin
            tests_failed++;
            $display("FAIL underrun_master_rx: got %h need 00", rx);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h01E4) begin
            tests_failed++;
            $display("FAIL underrun_status: got %h need 01e4", rd);
        end
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL underrun_irq: got %b need 1", irq);
        end
        bus_write(3'd2, 16'h0000);
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL underrun_irq_clear: got %b need 0", irq);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h0060) begin
            tests_failed++;
            $display("FAIL underrun_status_clear: got %h need 0060", rd);
        end
        bus_write(3'd3, 16'hFFFF);
        bus_read(3'd3, rd);
        tests_run++;
        if (rd !== 16'h01D8) begin
            tests_failed++;
            $display("FAIL control_mask: got %h need 01d8", rd);
        end
        bus_read(3'd5, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h need 0000", rd);
        end
        bus_write(3'd3, 16'h0000);
    endtask

    task automatic test_tx_overrun();
        logic [7:0]  rx;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h0011);
        bus_write(3'd1, 16'h0022);
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h0110) begin
            tests_failed++;
            $display("FAIL toe_status: got %h need 0110", rd);
        end
        spi_ss_fall();
        spi_byte(8'hC3, 1'b1, rx);
        tests_run++;
        if (rx !== 8'h11) begin
            tests_failed++;
            $display("FAIL toe_master_rx: got %h need 11", rx);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h01F0) begin
            tests_failed++;
            $display("FAIL toe_status_after: got %h need 01f0", rd);
        end
        bus_read(3'd0, rd);
        tests_run++;
        if (rd !== 16'h00C3) begin
            tests_failed++;
            $display("FAIL toe_rxdata: got %h need 00c3", rd);
        end
    endtask

    task automatic test_partial_frame();
        logic [7:0]  rx;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h00F0);
        spi_ss_fall();
        spi_clock_bits(8'h96, 4, rx);
        @(negedge clk);
        SS_n = 1'b1;
        repeat (HALF) @(negedge clk);
        tests_run++;
        if (dataavailable !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_rrdy: got %b need 0", dataavailable);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h0060) begin
            tests_failed++;
            $display("FAIL partial_status: got %h need 0060", rd);
        end
        bus_write(3'd1, 16'h0081);
        spi_ss_fall();
        spi_byte(8'h5A, 1'b1, rx);
        tests_run++;
        if (rx !== 8'h81) begin
            tests_failed++;
            $display("FAIL partial_next_master_rx: got %h need 81", rx);
        end
        bus_read(3'd0, rd);
        tests_run++;
        if (rd !== 16'h005A) begin
            tests_failed++;
            $display("FAIL partial_next_rxdata: got %h need 005a", rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  rx;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd3, 16'h0040);
        bus_write(3'd1, 16'h0077);
        spi_ss_fall();
        spi_clock_bits(8'h00, 2, rx);
        @(negedge clk);
        mem_addr = 3'd2;
        repeat (2) @(negedge clk);
        // 0x77 shifted twice puts bit 5 (=1) on MISO; TRDY with iTRDY drives irq.
        tests_run++;
        if (MISO !== 1'b1 || MISO_oe !== 1'b1 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_before_reset: miso=%b oe=%b irq=%b need 1 1 1", MISO, MISO_oe, irq);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (data_to_cpu !== 16'h0000 || irq !== 1'b0 || MISO !== 1'b0 || MISO_oe !== 1'b0 ||
            dataavailable !== 1'b0 || readyfordata !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: d=%h irq=%b miso=%b oe=%b da=%b rfd=%b, need 0000 0 0 0 0 1",
                     data_to_cpu, irq, MISO, MISO_oe, dataavailable, readyfordata);
        end
        @(negedge clk);
        SS_n = 1'b1;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_write(3'd1, 16'h003E);
        spi_ss_fall();
        spi_byte(8'hE7, 1'b1, rx);
        tests_run++;
        if (rx !== 8'h3E) begin
            tests_failed++;
            $display("FAIL mid_clean_master_rx: got %h need 3e", rx);
        end
        bus_read(3'd0, rd);
        tests_run++;
        if (rd !== 16'h00E7) begin
            tests_failed++;
            $display("FAIL mid_clean_rxdata: got %h need 00e7", rd);
        end
        bus_read(3'd2, rd);
        tests_run++;
        if (rd !== 16'h0060) begin
            tests_failed++;
            $display("FAIL mid_clean_status: got %h need 0060", rd);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n       = 1'b0;
        data_from_cpu = 16'h0000;
        mem_addr      = 3'd0;
        read_n        = 1'b1;
        write_n       = 1'b1;
        spi_select    = 1'b0;
        SCLK          = 1'b0;
        MOSI          = 1'b0;
        SS_n          = 1'b1;

        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underrun();
        test_tx_overrun();
        test_partial_frame();
        test_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
